// File: rtl/scr1_dp_mem_pkg.sv
`default_nettype none
// scr1_dp_mem_pkg: shared state type, read-latency constants and helpers for the pipelined dual-port TCM.
// Revision: 1.0
package scr1_dp_mem_pkg;

  typedef enum logic [0:0] {
    DPM_INIT  = 1'b0,
    DPM_READY = 1'b1
  } type_scr1_dpm_state_e;

  localparam int unsigned SCR1_DPM_RD_LAT_1 = 1;
  localparam int unsigned SCR1_DPM_RD_LAT_2 = 2;

  function automatic bit scr1_dpm_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scr1_dp_mem_array.sv
`default_nettype none
// scr1_dp_mem_array: raw storage with one byte-enabled write port and two registered read ports.
// Revision: 1.0
module scr1_dp_mem_array #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned NBYTES = WIDTH / 8
) (
  input  logic              clk_i,
  input  logic              rena_i,
  input  logic [AW-1:0]     addra_i,
  output logic [WIDTH-1:0]  qa_o,
  input  logic              renb_i,
  input  logic [AW-1:0]     addrb_i,
  output logic [WIDTH-1:0]  qb_o,
  input  logic              we_i,
  input  logic [NBYTES-1:0] be_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WIDTH-1:0]  wdata_i
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // Read registers see the pre-write word on a same-edge collision.
  always_ff @(posedge clk_i) begin
    if (rena_i) begin
      qa_o <= mem_q[addra_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (renb_i) begin
      qb_o <= mem_q[addrb_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/scr1_dp_memory_pipe.sv
`default_nettype none
// scr1_dp_memory_pipe: dual-port TCM with post-reset zero fill, write-first forwarding and 1/2-cycle reads.
// Revision: 1.0
module scr1_dp_memory_pipe
  import scr1_dp_mem_pkg::*;
#(
  parameter int unsigned SCR1_WIDTH   = 32,
  parameter int unsigned SCR1_SIZE    = 'h10000,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          WR_FORWARD   = 1'b1,
  parameter bit          INIT_ZERO    = 1'b1,
  localparam int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
  localparam int unsigned DEPTH       = SCR1_SIZE / SCR1_NBYTES,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic                   rena,
  input  logic [AW-1:0]          addra,
  output logic [SCR1_WIDTH-1:0]  qa,
  output logic                   qa_vld,
  input  logic                   renb,
  input  logic                   wenb,
  input  logic [SCR1_NBYTES-1:0] webb,
  input  logic [AW-1:0]          addrb,
  input  logic [SCR1_WIDTH-1:0]  datab,
  output logic [SCR1_WIDTH-1:0]  qb,
  output logic                   qb_vld
);

  if (SCR1_WIDTH % 8 != 0 || !scr1_dpm_is_pow2(SCR1_WIDTH)) begin : g_err_width
    $error("scr1_dp_memory_pipe: SCR1_WIDTH must be a power-of-two multiple of 8");
  end
  if (READ_LATENCY != SCR1_DPM_RD_LAT_1 && READ_LATENCY != SCR1_DPM_RD_LAT_2) begin : g_err_lat
    $error("scr1_dp_memory_pipe: READ_LATENCY must be 1 or 2");
  end
  if (!scr1_dpm_is_pow2(SCR1_SIZE)) begin : g_err_size
    $error("scr1_dp_memory_pipe: SCR1_SIZE must be a power of two");
  end

  function automatic logic [SCR1_WIDTH-1:0] merge_bytes(
    input logic [SCR1_WIDTH-1:0]  old_w,
    input logic [SCR1_WIDTH-1:0]  new_w,
    input logic [SCR1_NBYTES-1:0] be
  );
    logic [SCR1_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(SCR1_NBYTES); i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_w[i*8 +: 8];
      end
    end
    return res;
  endfunction

  type_scr1_dpm_state_e state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 ready_q;
  logic                 fill_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT_ZERO ? DPM_INIT : DPM_READY;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_q == DPM_READY);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_we = 1'b0;
    case (state_q)
      DPM_INIT: begin
        fill_we = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = DPM_READY;
        end
      end
      default: ;
    endcase
  end

  assign ready = ready_q;

  logic a_req, b_rd, b_wr;
  assign a_req = rena && ready_q;
  assign b_rd  = renb && ready_q;
  assign b_wr  = wenb && ready_q;

  logic                   arr_we;
  logic [SCR1_NBYTES-1:0] arr_be;
  logic [AW-1:0]          arr_waddr;
  logic [SCR1_WIDTH-1:0]  arr_wdata;
  logic [SCR1_WIDTH-1:0]  arr_qa, arr_qb;

  assign arr_we    = fill_we || b_wr;
  assign arr_be    = fill_we ? '1 : webb;
  assign arr_waddr = fill_we ? cnt_q : addrb;
  assign arr_wdata = fill_we ? '0 : datab;

  scr1_dp_mem_array #(
    .WIDTH  (SCR1_WIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .NBYTES (SCR1_NBYTES)
  ) u_array (
    .clk_i   (clk),
    .rena_i  (a_req),
    .addra_i (addra),
    .qa_o    (arr_qa),
    .renb_i  (b_rd),
    .addrb_i (addrb),
    .qb_o    (arr_qb),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata)
  );

  // Forward lanes are captured alongside the read; the array supplies the untouched bytes.
  logic [SCR1_NBYTES-1:0] a_fwd_be, b_fwd_be;
  assign a_fwd_be = (WR_FORWARD && b_wr && (addra == addrb)) ? webb : '0;
  assign b_fwd_be = (WR_FORWARD && b_wr) ? webb : '0;

  logic [SCR1_NBYTES-1:0] a_be_q, b_be_q;
  logic [SCR1_WIDTH-1:0]  a_wd_q, b_wd_q;
  logic                   a_seen_q, b_seen_q;
  logic                   a_vld1_q, b_vld1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_be_q   <= '0;
      a_wd_q   <= '0;
      a_seen_q <= 1'b0;
      a_vld1_q <= 1'b0;
    end else begin
      a_vld1_q <= a_req;
      if (a_req) begin
        a_be_q   <= a_fwd_be;
        a_wd_q   <= datab;
        a_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_be_q   <= '0;
      b_wd_q   <= '0;
      b_seen_q <= 1'b0;
      b_vld1_q <= 1'b0;
    end else begin
      b_vld1_q <= b_rd;
      if (b_rd) begin
        b_be_q   <= b_fwd_be;
        b_wd_q   <= datab;
        b_seen_q <= 1'b1;
      end
    end
  end

  // Until a port has been read its unreset array register is masked to zero.
  logic [SCR1_WIDTH-1:0] a_s1, b_s1;
  assign a_s1 = a_seen_q ? merge_bytes(arr_qa, a_wd_q, a_be_q) : '0;
  assign b_s1 = b_seen_q ? merge_bytes(arr_qb, b_wd_q, b_be_q) : '0;

  if (READ_LATENCY == SCR1_DPM_RD_LAT_2) begin : g_lat2
    logic [SCR1_WIDTH-1:0] qa_q, qb_q;
    logic                  qa_vld_q, qb_vld_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        qa_q     <= '0;
        qb_q     <= '0;
        qa_vld_q <= 1'b0;
        qb_vld_q <= 1'b0;
      end else begin
        qa_vld_q <= a_vld1_q;
        qb_vld_q <= b_vld1_q;
        if (a_vld1_q) begin
          qa_q <= a_s1;
        end
        if (b_vld1_q) begin
          qb_q <= b_s1;
        end
      end
    end

    assign qa     = qa_q;
    assign qb     = qb_q;
    assign qa_vld = qa_vld_q;
    assign qb_vld = qb_vld_q;
  end else begin : g_lat1
    assign qa     = a_s1;
    assign qb     = b_s1;
    assign qa_vld = a_vld1_q;
    assign qb_vld = b_vld1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_scr1_dp_memory_pipe.sv
`default_nettype none
// tb_scr1_dp_memory_pipe: directed and model-checked stimulus for three configurations sharing one input bus.
// Revision: 1.0
module tb_scr1_dp_memory_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rena = 1'b0, renb = 1'b0, wenb = 1'b0;
  logic [3:0]  addra = '0, addrb = '0, webb = '0;
  logic [31:0] datab = '0;

  // Instance 1: latency 1, forwarding; instance 2: latency 2, read-old; instance n: no zero fill.
  logic        rdy1, qav1, qbv1, rdy2, qav2, qbv2, rdyn, qavn, qbvn;
  logic [31:0] qa1, qb1, qa2, qb2, qan, qbn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE('h40), .READ_LATENCY(1), .WR_FORWARD(1'b1), .INIT_ZERO(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .ready(rdy1), .rena(rena), .addra(addra), .qa(qa1), .qa_vld(qav1),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb1), .qb_vld(qbv1));

  scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE('h40), .READ_LATENCY(2), .WR_FORWARD(1'b0), .INIT_ZERO(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .ready(rdy2), .rena(rena), .addra(addra), .qa(qa2), .qa_vld(qav2),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb2), .qb_vld(qbv2));

  scr1_dp_memory_pipe #(.SCR1_WIDTH(32), .SCR1_SIZE('h40), .READ_LATENCY(1), .WR_FORWARD(1'b1), .INIT_ZERO(1'b0)) u_nz (
    .clk(clk), .rst(rst), .ready(rdyn), .rena(rena), .addra(addra), .qa(qan), .qa_vld(qavn),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qbn), .qb_vld(qbvn));

  logic [31:0] model [16];

  task automatic idle();
    rena = 1'b0; renb = 1'b0; wenb = 1'b0; webb = '0;
  endtask

  task automatic write_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wenb = 1'b1; addrb = a; datab = d; webb = be;
    @(negedge clk);
    idle();
  endtask

  task automatic read_a(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    rena = 1'b1; addra = a;
    @(negedge clk);
    rena = 1'b0;
    checks++; if (qav1 !== 1'b1) begin errors++; $display("FAIL rd_a l1 vld: got %b exp 1 addr %0d", qav1, a); end
    checks++; if (qa1 !== e1) begin errors++; $display("FAIL rd_a l1 data: got %h exp %h addr %0d", qa1, e1, a); end
    checks++; if (qav2 !== 1'b0) begin errors++; $display("FAIL rd_a l2 early vld: got %b exp 0 addr %0d", qav2, a); end
    @(negedge clk);
    checks++; if (qav1 !== 1'b0) begin errors++; $display("FAIL rd_a l1 strobe: got %b exp 0 addr %0d", qav1, a); end
    checks++; if (qa1 !== e1) begin errors++; $display("FAIL rd_a l1 hold: got %h exp %h addr %0d", qa1, e1, a); end
    checks++; if (qav2 !== 1'b1) begin errors++; $display("FAIL rd_a l2 vld: got %b exp 1 addr %0d", qav2, a); end
    checks++; if (qa2 !== e2) begin errors++; $display("FAIL rd_a l2 data: got %h exp %h addr %0d", qa2, e2, a); end
  endtask

  task automatic read_b(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    renb = 1'b1; addrb = a;
    @(negedge clk);
    renb = 1'b0;
    checks++; if (qbv1 !== 1'b1) begin errors++; $display("FAIL rd_b l1 vld: got %b exp 1 addr %0d", qbv1, a); end
    checks++; if (qb1 !== e1) begin errors++; $display("FAIL rd_b l1 data: got %h exp %h addr %0d", qb1, e1, a); end
    checks++; if (qbv2 !== 1'b0) begin errors++; $display("FAIL rd_b l2 early vld: got %b exp 0 addr %0d", qbv2, a); end
    @(negedge clk);
    checks++; if (qbv2 !== 1'b1) begin errors++; $display("FAIL rd_b l2 vld: got %b exp 1 addr %0d", qbv2, a); end
    checks++; if (qb2 !== e2) begin errors++; $display("FAIL rd_b l2 data: got %h exp %h addr %0d", qb2, e2, a); end
  endtask

  // Counts edges after a release and checks the ready rise of both fill configurations.
  task automatic check_fill_window(input bit drive_traffic);
    if (drive_traffic) begin
      rena = 1'b1; renb = 1'b1; wenb = 1'b1; webb = 4'hF; datab = 32'hFFFF_FFFF; addra = 4'd0; addrb = 4'd0;
    end
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      checks++; if (rdy1 !== (n >= 17)) begin errors++; $display("FAIL fill ready l1 edge %0d: got %b exp %b", n, rdy1, (n >= 17)); end
      checks++; if (rdy2 !== (n >= 17)) begin errors++; $display("FAIL fill ready l2 edge %0d: got %b exp %b", n, rdy2, (n >= 17)); end
      checks++; if (rdyn !== 1'b1) begin errors++; $display("FAIL nz ready edge %0d: got %b exp 1", n, rdyn); end
      checks++; if (qav1 !== 1'b0 || qbv1 !== 1'b0) begin errors++; $display("FAIL fill vld l1 edge %0d: got %b%b exp 00", n, qav1, qbv1); end
      checks++; if (qav2 !== 1'b0 || qbv2 !== 1'b0) begin errors++; $display("FAIL fill vld l2 edge %0d: got %b%b exp 00", n, qav2, qbv2); end
      checks++; if (qa1 !== 32'h0) begin errors++; $display("FAIL fill qa l1 edge %0d: got %h exp 0", n, qa1); end
    end
    idle();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || rdyn !== 1'b0) begin errors++; $display("FAIL reset ready: got %b%b%b exp 000", rdy1, rdy2, rdyn); end
    checks++; if (qa1 !== 32'h0 || qb1 !== 32'h0) begin errors++; $display("FAIL reset q l1: got %h %h exp 0 0", qa1, qb1); end
    checks++; if (qa2 !== 32'h0 || qb2 !== 32'h0) begin errors++; $display("FAIL reset q l2: got %h %h exp 0 0", qa2, qb2); end
    checks++; if ({qav1, qbv1, qav2, qbv2} !== 4'b0) begin errors++; $display("FAIL reset vld: got %b exp 0000", {qav1, qbv1, qav2, qbv2}); end
    rst = 1'b1;
    check_fill_window(1'b1);
  endtask

  task automatic test_zero_fill();
    for (int i = 0; i < 16; i++) begin
      read_a(4'(i), 32'h0, 32'h0);
      read_b(4'(i), 32'h0, 32'h0);
    end
  endtask

  task automatic test_byte_write();
    write_b(4'd5, 32'hDEAD_BEEF, 4'hF);
    write_b(4'd5, 32'h0000_AA00, 4'b0010);
    read_a(4'd5, 32'hDEAD_AAEF, 32'hDEAD_AAEF);
    write_b(4'd5, 32'h1234_5678, 4'b0000);
    read_b(4'd5, 32'hDEAD_AAEF, 32'hDEAD_AAEF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    v[0] = 32'hA0A0_A0A0; v[1] = 32'hB1B1_B1B1; v[2] = 32'hC2C2_C2C2; v[3] = 32'hD3D3_D3D3;
    for (int i = 0; i < 4; i++) write_b(4'(8 + i), v[i], 4'hF);
    for (int k = 0; k < 6; k++) begin
      rena = (k < 4); addra = 4'(8 + k);
      @(negedge clk);
      checks++; if (qav1 !== (k <= 3)) begin errors++; $display("FAIL b2b l1 vld step %0d: got %b exp %b", k, qav1, (k <= 3)); end
      checks++; if (qa1 !== v[(k <= 3) ? k : 3]) begin errors++; $display("FAIL b2b l1 data step %0d: got %h exp %h", k, qa1, v[(k <= 3) ? k : 3]); end
      checks++; if (qav2 !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL b2b l2 vld step %0d: got %b exp %b", k, qav2, (k >= 1 && k <= 4)); end
      if (k >= 1) begin
        checks++; if (qa2 !== v[(k <= 4) ? k - 1 : 3]) begin errors++; $display("FAIL b2b l2 data step %0d: got %h exp %h", k, qa2, v[(k <= 4) ? k - 1 : 3]); end
      end
    end
    idle();
  endtask

  task automatic test_forward();
    write_b(4'd3, 32'h1122_3344, 4'hF);
    rena = 1'b1; addra = 4'd3; renb = 1'b1; wenb = 1'b1; addrb = 4'd3; webb = 4'b0001; datab = 32'h0000_00FF;
    @(negedge clk);
    idle();
    checks++; if (qa1 !== 32'h1122_33FF) begin errors++; $display("FAIL fwd a l1: got %h exp 112233ff", qa1); end
    checks++; if (qb1 !== 32'h1122_33FF) begin errors++; $display("FAIL fwd b l1: got %h exp 112233ff", qb1); end
    checks++; if (qav1 !== 1'b1 || qbv1 !== 1'b1) begin errors++; $display("FAIL fwd vld l1: got %b%b exp 11", qav1, qbv1); end
    @(negedge clk);
    checks++; if (qa2 !== 32'h1122_3344) begin errors++; $display("FAIL fwd a l2 old: got %h exp 11223344", qa2); end
    checks++; if (qb2 !== 32'h1122_3344) begin errors++; $display("FAIL fwd b l2 old: got %h exp 11223344", qb2); end
    checks++; if (qav2 !== 1'b1 || qbv2 !== 1'b1) begin errors++; $display("FAIL fwd vld l2: got %b%b exp 11", qav2, qbv2); end
    checks++; if (qa1 !== 32'h1122_33FF) begin errors++; $display("FAIL fwd hold l1: got %h exp 112233ff", qa1); end
    read_a(4'd3, 32'h1122_33FF, 32'h1122_33FF);
    rena = 1'b1; addra = 4'd4; wenb = 1'b1; addrb = 4'd3; webb = 4'hF; datab = 32'h5566_7788;
    @(negedge clk);
    idle();
    checks++; if (qa1 !== 32'h0) begin errors++; $display("FAIL nofwd a l1: got %h exp 0", qa1); end
    @(negedge clk);
    checks++; if (qa2 !== 32'h0) begin errors++; $display("FAIL nofwd a l2: got %h exp 0", qa2); end
    read_b(4'd3, 32'h5566_7788, 32'h5566_7788);
  endtask

  task automatic test_reset_midfill();
    rst = 1'b0;
    #1;
    checks++; if (qb1 !== 32'h0 || qb2 !== 32'h0) begin errors++; $display("FAIL async reset qb: got %h %h exp 0 0", qb1, qb2); end
    checks++; if (rdy1 !== 1'b0 || rdyn !== 1'b0) begin errors++; $display("FAIL async reset ready: got %b%b exp 00", rdy1, rdyn); end
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_fill_window(1'b0);
    read_a(4'd10, 32'h0, 32'h0);
    read_b(4'd11, 32'h0, 32'h0);
    read_a(4'd3, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic        ra, rb, wb, p2a, p2b;
    logic [3:0]  aa, ab, be;
    logic [31:0] d, old_a, old_b, merged, fa, fb, h1a, h1b, h2a, h2b, p2a_d, p2b_d;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    h1a = '0; h1b = '0; h2a = '0; h2b = '0; p2a = 1'b0; p2b = 1'b0; p2a_d = '0; p2b_d = '0;
    for (int c = 0; c < 600; c++) begin
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      aa = 4'($urandom_range(0, 7)); ab = 4'($urandom_range(0, 7)); be = 4'($urandom_range(0, 15));
      d = $urandom;
      old_a = model[aa]; old_b = model[ab]; merged = old_b;
      for (int j = 0; j < 4; j++) if (be[j]) merged[j*8 +: 8] = d[j*8 +: 8];
      fa = (wb && aa == ab) ? merged : old_a;
      fb = wb ? merged : old_b;
      if (wb) model[ab] = merged;
      rena = ra; renb = rb; wenb = wb; addra = aa; addrb = ab; webb = be; datab = d;
      @(negedge clk);
      if (ra) h1a = fa;
      if (rb) h1b = fb;
      if (p2a) h2a = p2a_d;
      if (p2b) h2b = p2b_d;
      checks++; if (qav1 !== ra || qa1 !== h1a) begin errors++; $display("FAIL rnd a l1 cyc %0d: got %b %h exp %b %h", c, qav1, qa1, ra, h1a); end
      checks++; if (qbv1 !== rb || qb1 !== h1b) begin errors++; $display("FAIL rnd b l1 cyc %0d: got %b %h exp %b %h", c, qbv1, qb1, rb, h1b); end
      checks++; if (qav2 !== p2a || qa2 !== h2a) begin errors++; $display("FAIL rnd a l2 cyc %0d: got %b %h exp %b %h", c, qav2, qa2, p2a, h2a); end
      checks++; if (qbv2 !== p2b || qb2 !== h2b) begin errors++; $display("FAIL rnd b l2 cyc %0d: got %b %h exp %b %h", c, qbv2, qb2, p2b, h2b); end
      p2a = ra; p2a_d = old_a; p2b = rb; p2b_d = old_b;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_byte_write();
    test_back_to_back();
    test_forward();
    test_reset_midfill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
